// File: rtl/i2c_master_ctrl_pkg.sv
// Shared definitions for the memory-mapped I2C master.
// Holds the FSM state encodings, the IO offsets decoded on the load side,
// the status word layout and the latched command payload.
package i2c_master_ctrl_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEV_W   = 7;
    localparam int unsigned RDATA_W = 16;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_TX_BYTE = 3'd2;
    localparam logic [2:0] ST_RX_ACK  = 3'd3;
    localparam logic [2:0] ST_RSTART  = 3'd4;
    localparam logic [2:0] ST_RX_BYTE = 3'd5;
    localparam logic [2:0] ST_TX_ACK  = 3'd6;
    localparam logic [2:0] ST_STOP    = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        TX_BYTE = ST_TX_BYTE,
        RX_ACK  = ST_RX_ACK,
        RSTART  = ST_RSTART,
        RX_BYTE = ST_RX_BYTE,
        TX_ACK  = ST_TX_ACK,
        STOP    = ST_STOP
    } state_e;

    // Which byte of the transaction is in flight
    typedef enum logic [2:0] {
        STEP_ADDR_W = 3'd0,   // {dev,0}
        STEP_REG    = 3'd1,   // register address
        STEP_BYTE2  = 3'd2,   // write data, or {dev,1} for reads
        STEP_RX0    = 3'd3,   // first read byte
        STEP_RX1    = 3'd4    // second read byte
    } step_e;

    // IO offsets matching the load-side decode
    localparam logic [11:0] I2C_STATUS = 12'h100;
    localparam logic [11:0] I2C_RDATA  = 12'h104;

    // Status word layout
    localparam int unsigned STAT_READY_BIT  = 0;
    localparam int unsigned STAT_RVALID_BIT = 1;

    typedef struct packed {
        logic              rw;
        logic              two_byte;
        logic [DEV_W-1:0]  dev_addr;
        logic [DATA_W-1:0] reg_addr;
        logic [DATA_W-1:0] wdata;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_master_ctrl_bit_timer.sv
// Bit-slot timer: divides clk into quarter-bit phases.
// Ports: run (count enable, counters held clear when low),
//        tick_c (one-cycle pulse at divider wrap), phase (0..3 within a slot),
//        slot_end_c (tick in phase 3, last cycle of a slot).
module i2c_bit_timer #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       tick_c,
    output logic [1:0] phase,
    output logic       slot_end_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c     = run && (cnt == CNT_W'(CLK_DIV - 1));
    assign slot_end_c = tick_c && (phase == 2'd3);

    // Divider and phase counter, both cleared while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (tick_c) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Memory-mapped I2C master: register write (1 byte) and register read (1 or 2 bytes).
// Ports: cmd_* command handshake (accepted while ctrl_ready=1), rdata_ack clears
//        rdata_valid, rdata/rdata_valid/nack_err results, scl_oe/sda_oe open-drain
//        pull-downs, sda_i raw SDA line (synchronized internally).
module i2c_master_ctrl
    import i2c_master_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic                cmd_rw,
    input  logic                cmd_two_byte,
    input  logic [DEV_W-1:0]    cmd_dev_addr,
    input  logic [DATA_W-1:0]   cmd_reg_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic                rdata_ack,
    output logic                ctrl_ready,
    output logic                rdata_valid,
    output logic [RDATA_W-1:0]  rdata,
    output logic                nack_err,
    output logic                scl_oe,
    output logic                sda_oe,
    input  logic                sda_i
);

    state_e              state, state_n;
    step_e               step, step_n;
    i2c_cmd_t            cmd, cmd_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   tx_byte, tx_byte_n;
    logic [DATA_W-1:0]   rx_byte, rx_byte_n;
    logic [DATA_W-1:0]   rx_b0, rx_b0_n;
    logic                nack_q, nack_q_n;
    logic                ctrl_ready_n, rdata_valid_n, nack_err_n;
    logic [RDATA_W-1:0]  rdata_n;
    logic                scl_oe_n, sda_oe_n;
    logic [1:0]          phase, phase_n;
    logic                tick_c, slot_end_c, sample_c, busy_c;
    logic                sda_s1, sda_s2;

    assign busy_c   = (state != IDLE);
    // sda_i is sampled on the edge that starts phase 3
    assign sample_c = tick_c && (phase == 2'd2);

    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (busy_c),
        .tick_c     (tick_c),
        .phase      (phase),
        .slot_end_c (slot_end_c)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= STEP_ADDR_W;
            cmd         <= '0;
            bit_cnt     <= 3'd0;
            tx_byte     <= '0;
            rx_byte     <= '0;
            rx_b0       <= '0;
            nack_q      <= 1'b0;
            ctrl_ready  <= 1'b1;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            nack_err    <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            sda_s1      <= 1'b1;
            sda_s2      <= 1'b1;
        end else begin
            state       <= state_n;
            step        <= step_n;
            cmd         <= cmd_n;
            bit_cnt     <= bit_cnt_n;
            tx_byte     <= tx_byte_n;
            rx_byte     <= rx_byte_n;
            rx_b0       <= rx_b0_n;
            nack_q      <= nack_q_n;
            ctrl_ready  <= ctrl_ready_n;
            rdata_valid <= rdata_valid_n;
            rdata       <= rdata_n;
            nack_err    <= nack_err_n;
            scl_oe      <= scl_oe_n;
            sda_oe      <= sda_oe_n;
            sda_s1      <= sda_i;
            sda_s2      <= sda_s1;
        end
    end

    // Next-state, datapath and bus drive for the upcoming phase
    always_comb begin
        state_n       = state;
        step_n        = step;
        cmd_n         = cmd;
        bit_cnt_n     = bit_cnt;
        tx_byte_n     = tx_byte;
        rx_byte_n     = rx_byte;
        rx_b0_n       = rx_b0;
        nack_q_n      = nack_q;
        ctrl_ready_n  = ctrl_ready;
        rdata_valid_n = rdata_valid & ~rdata_ack;
        rdata_n       = rdata;
        nack_err_n    = nack_err;
        scl_oe_n      = 1'b0;
        sda_oe_n      = 1'b0;
        phase_n       = tick_c ? (phase + 2'd1) : phase;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_n = '{rw: cmd_rw, two_byte: cmd_two_byte, dev_addr: cmd_dev_addr,
                              reg_addr: cmd_reg_addr, wdata: cmd_wdata};
                    state_n       = START;
                    ctrl_ready_n  = 1'b0;
                    nack_err_n    = 1'b0;
                    rdata_valid_n = 1'b0;
                end
            end
            START: begin
                if (slot_end_c) begin
                    state_n   = TX_BYTE;
                    step_n    = STEP_ADDR_W;
                    tx_byte_n = {cmd.dev_addr, 1'b0};
                    bit_cnt_n = 3'd7;
                end
            end
            TX_BYTE: begin
                if (slot_end_c) begin
                    tx_byte_n = {tx_byte[DATA_W-2:0], 1'b0};
                    if (bit_cnt == 3'd0) begin
                        state_n = RX_ACK;
                    end else begin
                        bit_cnt_n = bit_cnt - 3'd1;
                    end
                end
            end
            RX_ACK: begin
                if (sample_c) begin
                    nack_q_n = sda_s2;
                end
                if (slot_end_c) begin
                    bit_cnt_n = 3'd7;
                    if (nack_q) begin
                        state_n    = STOP;
                        nack_err_n = 1'b1;
                    end else begin
                        unique case (step)
                            STEP_ADDR_W: begin
                                state_n   = TX_BYTE;
                                step_n    = STEP_REG;
                                tx_byte_n = cmd.reg_addr;
                            end
                            STEP_REG: begin
                                if (cmd.rw) begin
                                    state_n = RSTART;
                                end else begin
                                    state_n   = TX_BYTE;
                                    step_n    = STEP_BYTE2;
                                    tx_byte_n = cmd.wdata;
                                end
                            end
                            STEP_BYTE2: begin
                                if (cmd.rw) begin
                                    state_n = RX_BYTE;
                                    step_n  = STEP_RX0;
                                end else begin
                                    state_n = STOP;
                                end
                            end
                            default: state_n = STOP;
                        endcase
                    end
                end
            end
            RSTART: begin
                if (slot_end_c) begin
                    state_n   = TX_BYTE;
                    step_n    = STEP_BYTE2;
                    tx_byte_n = {cmd.dev_addr, 1'b1};
                    bit_cnt_n = 3'd7;
                end
            end
            RX_BYTE: begin
                if (sample_c) begin
                    rx_byte_n = {rx_byte[DATA_W-2:0], sda_s2};
                end
                if (slot_end_c) begin
                    if (bit_cnt == 3'd0) begin
                        state_n = TX_ACK;
                    end else begin
                        bit_cnt_n = bit_cnt - 3'd1;
                    end
                end
            end
            TX_ACK: begin
                if (slot_end_c) begin
                    if ((step == STEP_RX0) && cmd.two_byte) begin
                        state_n   = RX_BYTE;
                        step_n    = STEP_RX1;
                        rx_b0_n   = rx_byte;
                        bit_cnt_n = 3'd7;
                    end else begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (slot_end_c) begin
                    state_n      = IDLE;
                    ctrl_ready_n = 1'b1;
                    if (cmd.rw && !nack_err) begin
                        rdata_valid_n = 1'b1;
                        rdata_n = cmd.two_byte ? {rx_b0, rx_byte} : {8'h00, rx_byte};
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // SCL is low in phases 0-1 of every slot except START
        unique case (state_n)
            IDLE: begin
                scl_oe_n = 1'b0;
                sda_oe_n = 1'b0;
            end
            START: begin
                scl_oe_n = (phase_n == 2'd3);
                sda_oe_n = phase_n[1];
            end
            RSTART: begin
                scl_oe_n = ~phase_n[1];
                sda_oe_n = (phase_n == 2'd3);
            end
            STOP: begin
                scl_oe_n = ~phase_n[1];
                sda_oe_n = (phase_n != 2'd3);
            end
            TX_BYTE: begin
                scl_oe_n = ~phase_n[1];
                sda_oe_n = ~tx_byte_n[DATA_W-1];
            end
            TX_ACK: begin
                // ACK only after the first byte of a two-byte read
                scl_oe_n = ~phase_n[1];
                sda_oe_n = (step_n == STEP_RX0) && cmd_n.two_byte;
            end
            default: begin
                scl_oe_n = ~phase_n[1];
                sda_oe_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl with a behavioural I2C slave.
// The slave/monitor decodes bus traffic into tokens that are compared against
// an expected-token scoreboard filled when each command is issued.
module tb_i2c_master_ctrl;

    localparam logic [11:0] TOK_START = 12'h400;
    localparam logic [11:0] TOK_STOP  = 12'h800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_rw;
    logic        cmd_two_byte;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr;
    logic [7:0]  cmd_wdata;
    logic        rdata_ack;
    logic        ctrl_ready;
    logic        rdata_valid;
    logic [15:0] rdata;
    logic        nack_err;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda_line;

    // Slave model state
    logic        slave_pull = 1'b0;
    logic        slave_nack = 1'b0;
    logic [7:0]  slave_rd [2];
    logic        mon_en = 1'b0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    int          bit_idx = 0;
    int          frame_byte = 0;
    int          rd_idx = 0;
    logic        read_mode = 1'b0;
    logic        rd_done = 1'b0;
    logic [7:0]  shreg = 8'h00;

    logic [11:0] sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign sda_line = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_rw       (cmd_rw),
        .cmd_two_byte (cmd_two_byte),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rdata_ack    (rdata_ack),
        .ctrl_ready   (ctrl_ready),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .nack_err     (nack_err),
        .scl_oe       (scl_oe),
        .sda_oe       (sda_oe),
        .sda_i        (sda_line)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] tk(input logic [7:0] b, input logic nak);
        return {3'b000, nak, b};
    endfunction

    task automatic sb_check(input logic [11:0] tok);
        logic [11:0] exp_tok;
        if (sb_q.size() == 0) begin
            check_eq("bus_unexpected", 32'(tok), 32'hFFF);
        end else begin
            exp_tok = sb_q.pop_front();
            check_eq("bus_token", 32'(tok), 32'(exp_tok));
        end
    endtask

    // Bus monitor and slave, sampled away from the DUT clock edge
    always @(negedge clk) begin
        logic       scl_now;
        logic       sda_now;
        logic [7:0] rb;
        if (mon_en) begin
            scl_now = ~scl_oe;
            sda_now = sda_line;
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                sb_check(TOK_START);
                bit_idx    = 0;
                frame_byte = 0;
                read_mode  = 1'b0;
                rd_done    = 1'b0;
                rd_idx     = 0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                sb_check(TOK_STOP);
                slave_pull = 1'b0;
            end else if (!prev_scl && scl_now) begin
                if (bit_idx < 8) begin
                    shreg   = {shreg[6:0], sda_now};
                    bit_idx = bit_idx + 1;
                end else begin
                    sb_check(tk(shreg, sda_now));
                    if (frame_byte == 0) begin
                        read_mode = shreg[0];
                    end else if (read_mode) begin
                        rd_idx = rd_idx + 1;
                        if (sda_now) rd_done = 1'b1;
                    end
                    frame_byte = frame_byte + 1;
                    bit_idx    = 0;
                end
            end else if (prev_scl && !scl_now) begin
                if (bit_idx == 8 && (frame_byte == 0 || !read_mode)) begin
                    slave_pull = !(slave_nack && frame_byte == 0);
                end else if (bit_idx < 8 && read_mode && frame_byte >= 1 && !rd_done && rd_idx < 2) begin
                    rb = slave_rd[rd_idx];
                    slave_pull = ~rb[3'(7 - bit_idx)];
                end else begin
                    slave_pull = 1'b0;
                end
            end
            prev_scl = scl_now;
            prev_sda = sda_now;
        end
    end

    // Issue one command, track its busy window and check results at completion
    task automatic run_cmd(input logic rw, input logic two, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd,
                           input int exp_cyc, input int ack_at, input int poke_at,
                           input logic exp_valid, input logic [15:0] exp_rdata,
                           input logic exp_nack);
        int   n;
        logic done;
        sb_q.push_back(TOK_START);
        if (slave_nack) begin
            sb_q.push_back(tk({dev, 1'b0}, 1'b1));
        end else begin
            sb_q.push_back(tk({dev, 1'b0}, 1'b0));
            sb_q.push_back(tk(ra, 1'b0));
            if (!rw) begin
                sb_q.push_back(tk(wd, 1'b0));
            end else begin
                sb_q.push_back(TOK_START);
                sb_q.push_back(tk({dev, 1'b1}, 1'b0));
                if (two) begin
                    sb_q.push_back(tk(slave_rd[0], 1'b0));
                    sb_q.push_back(tk(slave_rd[1], 1'b1));
                end else begin
                    sb_q.push_back(tk(slave_rd[0], 1'b1));
                end
            end
        end
        sb_q.push_back(TOK_STOP);

        @(negedge clk);
        cmd_rw       = rw;
        cmd_two_byte = two;
        cmd_dev_addr = dev;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq("ready_drop", 32'(ctrl_ready), 32'h0);

        n    = 0;
        done = 1'b0;
        while (!done && n < 2000) begin
            @(posedge clk);
            n = n + 1;
            #1;
            rdata_ack = (n == ack_at);
            cmd_valid = (n == poke_at);
            if (n == poke_at) begin
                cmd_dev_addr = 7'h55;
                cmd_rw       = ~rw;
            end
            if (ctrl_ready) done = 1'b1;
        end
        rdata_ack = 1'b0;
        cmd_valid = 1'b0;
        check_eq("busy_cycles", 32'(n), 32'(exp_cyc));
        check_eq("done_rvalid", 32'(rdata_valid), 32'(exp_valid));
        check_eq("done_rdata", 32'(rdata), 32'(exp_rdata));
        check_eq("done_nack", 32'(nack_err), 32'(exp_nack));

        repeat (32) @(posedge clk);
        #1;
        check_eq("ready_idle", 32'(ctrl_ready), 32'h1);
        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_rw       = 1'b0;
        cmd_two_byte = 1'b0;
        cmd_dev_addr = 7'h00;
        cmd_reg_addr = 8'h00;
        cmd_wdata    = 8'h00;
        rdata_ack    = 1'b0;
        slave_rd[0]  = 8'h00;
        slave_rd[1]  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ctrl_ready), 32'h1);
        check_eq("rst_rvalid", 32'(rdata_valid), 32'h0);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        check_eq("rst_nack", 32'(nack_err), 32'h0);
        check_eq("rst_scl", 32'(scl_oe), 32'h0);
        check_eq("rst_sda", 32'(sda_oe), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of the address byte
        @(negedge clk);
        cmd_rw       = 1'b0;
        cmd_two_byte = 1'b0;
        cmd_dev_addr = 7'h1A;
        cmd_reg_addr = 8'h05;
        cmd_wdata    = 8'h3C;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check_eq("midtx_ready", 32'(ctrl_ready), 32'h0);
        check_eq("midtx_scl", 32'(scl_oe), 32'h1);
        check_eq("midtx_sda", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_scl", 32'(scl_oe), 32'h0);
        check_eq("arst_sda", 32'(sda_oe), 32'h0);
        check_eq("arst_ready", 32'(ctrl_ready), 32'h1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_scl", 32'(scl_oe), 32'h0);
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        mon_en   = 1'b1;

        // Register write
        slave_nack = 1'b0;
        run_cmd(1'b0, 1'b0, 7'h1A, 8'h05, 8'h3C, 464, -1, -1, 1'b0, 16'h0000, 1'b0);

        // One-byte read: busy-time command ignored, ack coincident with completion
        slave_rd[0] = 8'hA5;
        slave_rd[1] = 8'h00;
        run_cmd(1'b1, 1'b0, 7'h1A, 8'h10, 8'h00, 624, 623, 100, 1'b1, 16'h00A5, 1'b0);

        // Later ack clears rdata_valid, data held
        @(negedge clk);
        rdata_ack = 1'b1;
        @(posedge clk);
        #1;
        rdata_ack = 1'b0;
        check_eq("ack_clears_rvalid", 32'(rdata_valid), 32'h0);
        check_eq("ack_keeps_rdata", 32'(rdata), 32'h00A5);

        // Two-byte read
        slave_rd[0] = 8'h12;
        slave_rd[1] = 8'h34;
        run_cmd(1'b1, 1'b1, 7'h1A, 8'h10, 8'h00, 768, -1, -1, 1'b1, 16'h1234, 1'b0);

        // Slave NACKs the address byte: STOP after 11 slots, rdata untouched
        slave_nack = 1'b1;
        run_cmd(1'b1, 1'b0, 7'h1A, 8'h10, 8'h00, 176, -1, -1, 1'b0, 16'h1234, 1'b1);

        // Next accept clears the sticky NACK
        slave_nack = 1'b0;
        run_cmd(1'b0, 1'b0, 7'h2B, 8'hFF, 8'h81, 464, -1, -1, 1'b0, 16'h1234, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Memory-mapped I2C master that sits directly upstream of the CPU load path. It produces the i2c_ctrl_ready, i2c_rdata_valid and i2c_rdata signals that loads from IO offsets 0x100 (status) and 0x104 (read byte) return. It accepts one register-write or register-read command per handshake from the IO store decoder and drives an open-drain SCL/SDA pair. The target is 7-bit addressing, 8-bit register address, 1- or 2-byte reads, single-byte writes, with no clock stretching and no multi-master support.

Parameters:
CLK_DIV, 125, core cycles per quarter bit period (bit = 4*CLK_DIV cycles; 100 kHz at 50 MHz). Must be >= 2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe from IO store decoder; sampled only when ctrl_ready=1
cmd_rw  in  1  0 = register write, 1 = register read
cmd_two_byte  in  1  read only: 1 = read two bytes
cmd_dev_addr  in  7  7-bit slave address
cmd_reg_addr  in  8  slave register address
cmd_wdata  in  8  write data byte
rdata_ack  in  1  pulse from load of offset 0x104; clears rdata_valid
ctrl_ready  out  1  idle, can accept a command
rdata_valid  out  1  read result held in rdata
rdata  out  16  1-byte read: {8'h00,b0}; 2-byte read: {b0,b1}
nack_err  out  1  sticky; slave NACKed the last command
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  synchronized SDA input (2-flop synchronizer inside block)

Behaviour:
- Reset (async, rst_n=0):
  - ctrl_ready=1; rdata_valid=0; rdata=0; nack_err=0; scl_oe=0; sda_oe=0.
  - FSM goes to IDLE; tick and phase counters clear.
  - Reset mid-transfer releases the bus immediately. No bus-recovery sequence is generated.
- Timing:
  - The tick counter counts 0..CLK_DIV-1 and pulses at wrap.
  - The phase counter counts 0..3 per tick.
  - Every bit slot spans 4 phases. SCL is low in phases 0-1 and released in phases 2-3.
  - SDA changes only at the start of phase 0. sda_i is sampled at the start of phase 3.
- Accept:
  - In IDLE with cmd_valid=1, all cmd_* fields are latched.
  - ctrl_ready drops the next cycle. nack_err and rdata_valid clear on accept.
  - cmd_valid while ctrl_ready=0 is ignored.
- FSM states: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP.
- START (1 slot): SDA released in phases 0-1, SDA pulled low in phase 2 with SCL high, SCL pulled low in phase 3.
- TX_BYTE (8 slots, MSB first) is followed by RX_ACK (1 slot). sda_i=0 means ACK.
- Write sequence: START, {dev,0}, reg, wdata, STOP. Total 29 slots.
- Read sequence: START, {dev,0}, reg, RSTART, {dev,1}, RX_BYTE b0, then:
  - 2-byte read: master ACK (sda_oe=1), RX_BYTE b1, master NACK.
  - 1-byte read: master NACK (sda_oe=0).
  - STOP follows the final NACK. Totals: 39 slots (1 byte), 48 slots (2 bytes).
- RSTART (1 slot): SDA released in phase 0 with SCL low, SCL released in phase 2, SDA pulled low in phase 3.
- STOP (1 slot): SDA low in phase 0, SCL released in phase 2, SDA released in phase 3.
- Slave NACK in any RX_ACK:
  - Go to STOP at the next slot.
  - nack_err=1; rdata_valid stays 0; rdata is unchanged.
- Completion:
  - On the final cycle of STOP phase 3: FSM goes to IDLE and ctrl_ready=1 the next cycle.
  - For a successful read, rdata is updated and rdata_valid=1 in the same cycle.
- rdata_valid:
  - Cleared by rdata_ack.
  - If set and rdata_ack coincide, set wins.
- RX_BYTE shifts sda_i into an 8-bit register, MSB first. The bit counter runs 7..0; underflow moves to the ack state.

Decomposition:
- Shared include holds:
  - state encodings (3-bit localparams);
  - IO offsets I2C_STATUS=12'h100 and I2C_RDATA=12'h104, matching the load-side decode;
  - status bit layout: bit0 = ctrl_ready, bit1 = rdata_valid.
- One natural sub-module, i2c_bit_timer: takes CLK_DIV and produces the tick, phase[1:0] and slot_end pulses. The FSM, shifter and synchronizer stay in i2c_master_ctrl.

Test Plan:
- Reset → outputs: rst_n low mid-TX_BYTE → scl_oe=0, sda_oe=0, ctrl_ready=1 within the same cycle (async). Bench uses CLK_DIV=4 (slot = 16 cycles).
- Register write: write dev=0x1A, reg=0x05, data=0x3C, slave model ACKs all → bus bytes 0x34, 0x05, 0x3C with START/STOP; ctrl_ready low for exactly 29*16=464 cycles; nack_err=0, rdata_valid=0.
- One-byte read: read dev=0x1A, reg=0x10, slave returns 0xA5 → bytes 0x34, 0x10, RSTART, 0x35; master NACK; rdata=0x00A5 and rdata_valid=1 after 39*16=624 cycles.
- Two-byte read: slave returns 0x12 then 0x34 → master ACK after first byte, NACK after second; rdata=0x1234 after 768 cycles.
- Slave NACK: slave NACKs address byte → STOP follows; nack_err=1; rdata_valid=0; ctrl_ready returns after 11 slots (176 cycles).
- Handshake edge cases:
  - cmd_valid while busy → ignored, no second transaction.
  - rdata_ack coincident with read completion → rdata_valid=1.
  - rdata_ack afterwards → rdata_valid=0.
